cic_rate_ctrl: RTL and testbench

//  Sequences sample-rate changes for the two-stage CIC decimator chain
//  (varcic1 -> varcic2). Maps a host rate code to the decimation pair and

---
 rtl/cic_rate_ctrl_pkg.sv | 27 ++
 rtl/cic_rate_ctrl_if.sv | 23 ++
 rtl/cic_rate_ctrl_sync2.sv | 16 +
 rtl/cic_rate_ctrl.sv | 73 +++++++
 tb/tb_cic_rate_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cic_rate_ctrl_pkg.sv
// cic_rate_ctrl_pkg: rate codes, decimation table and FSM encoding for the CIC rate controller
package cic_rate_ctrl_pkg;
    localparam logic [2:0] SEL_800 = 3'd0;
    localparam logic [2:0] SEL_400 = 3'd1;
    localparam logic [2:0] SEL_200 = 3'd2;
    localparam logic [2:0] SEL_100 = 3'd3;
    localparam logic [2:0] SEL_50  = 3'd4;

    typedef enum logic [1:0] {FLUSH, SETTLE, RUN} state_t;

    typedef struct packed {
        logic [7:0] dec1;
        logic [6:0] dec2;
        logic       ok;
    } rate_t;

    function automatic rate_t rate_lut(input logic [2:0] sel);
        case (sel)
            SEL_800: rate_lut = '{dec1: 8'd40, dec2: 7'd20, ok: 1'b1};
            SEL_400: rate_lut = '{dec1: 8'd20, dec2: 7'd20, ok: 1'b1};
            SEL_200: rate_lut = '{dec1: 8'd10, dec2: 7'd20, ok: 1'b1};
            SEL_100: rate_lut = '{dec1: 8'd10, dec2: 7'd10, ok: 1'b1};
            SEL_50:  rate_lut = '{dec1: 8'd5,  dec2: 7'd10, ok: 1'b1};
            default: rate_lut = '{dec1: 8'd0,  dec2: 7'd0,  ok: 1'b0};
        endcase
    endfunction
endpackage

// File: rtl/cic_rate_ctrl_if.sv
// cic_rate_ctrl_if: host/datapath signals between the rate controller and the CIC chain
interface cic_rate_ctrl_if;
    logic [2:0] rate_sel;
    logic       in_strobe;
    logic       cic2_strobe;
    logic [7:0] dec1;
    logic [6:0] dec2;
    logic       cic1_strobe;
    logic       cic_clr;
    logic       out_valid;
    logic       busy;
    logic       rate_ack;
    logic       sel_err;

    modport master (
        output rate_sel, in_strobe, cic2_strobe,
        input  dec1, dec2, cic1_strobe, cic_clr, out_valid, busy, rate_ack, sel_err
    );
    modport slave (
        input  rate_sel, in_strobe, cic2_strobe,
        output dec1, dec2, cic1_strobe, cic_clr, out_valid, busy, rate_ack, sel_err
    );
endinterface

// File: rtl/cic_rate_ctrl_sync2.sv
// cic_rate_ctrl_sync2: two-flop synchroniser for the quasi-static host rate code
module cic_rate_ctrl_sync2 #(
    parameter int             W   = 3,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] m_q;

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) {q_o, m_q} <= {RST, RST};
        else        {q_o, m_q} <= {m_q, d_i};
endmodule

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: sequences CIC decimation changes with flush, settle blanking and rate acknowledge
module cic_rate_ctrl
    import cic_rate_ctrl_pkg::*;
#(
    parameter int         FLUSH_CYCLES   = 16,
    parameter int         SETTLE_SAMPLES = 12,
    parameter logic [2:0] DEFAULT_SEL    = 3'd0
) (
    input logic             clock,
    input logic             rst_n,
    cic_rate_ctrl_if.slave  bus
);
    localparam int          CW    = $clog2(FLUSH_CYCLES > SETTLE_SAMPLES ? FLUSH_CYCLES : SETTLE_SAMPLES);
    localparam logic [CW-1:0] F_LD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] S_LD = CW'(SETTLE_SAMPLES - 1);
    localparam rate_t       DEF_R = rate_lut(DEFAULT_SEL);

    logic [2:0]    sel_s, sel_p_q, acc_q;
    logic [7:0]    dec1_q;
    logic [6:0]    dec2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rate_t         new_r;
    logic          chg, expd, strb;

    cic_rate_ctrl_sync2 #(.W(3), .RST(DEFAULT_SEL)) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d_i   (bus.rate_sel),
        .q_o   (sel_s)
    );

    assign new_r = rate_lut(sel_s);
    assign chg   = new_r.ok && sel_s != acc_q;
    assign expd  = cnt_q == '0;
    assign strb  = state_q == SETTLE && bus.cic2_strobe;

    // a fresh valid code always wins over counter expiry and restarts the flush
    assign state_d = chg ? FLUSH
                   : state_q == FLUSH ? (expd ? SETTLE : FLUSH)
                   : strb && expd ? RUN : state_q;
    assign cnt_d   = chg ? F_LD
                   : state_q == FLUSH ? (expd ? S_LD : cnt_q - 1'b1)
                   : strb && !expd ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            state_q <= FLUSH;
            cnt_q   <= F_LD;
            acc_q   <= DEFAULT_SEL;
            sel_p_q <= DEFAULT_SEL;
            dec1_q  <= DEF_R.dec1;
            dec2_q  <= DEF_R.dec2;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_p_q <= sel_s;
            if (chg) begin
                acc_q  <= sel_s;
                dec1_q <= new_r.dec1;
                dec2_q <= new_r.dec2;
            end
        end

    assign bus.dec1        = dec1_q;
    assign bus.dec2        = dec2_q;
    assign bus.cic_clr     = state_q == FLUSH;
    assign bus.busy        = state_q != RUN;
    assign bus.cic1_strobe = bus.in_strobe && state_q != FLUSH;
    assign bus.out_valid   = state_q == RUN && bus.cic2_strobe;
    assign bus.rate_ack    = strb && expd && !chg;
    assign bus.sel_err     = !new_r.ok && sel_s != sel_p_q;
endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb_cic_rate_ctrl: random-stimulus bench comparing the rate controller to a cycle-count model
module tb_cic_rate_ctrl;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    cic_rate_ctrl_if bus();

    cic_rate_ctrl #(.FLUSH_CYCLES(16), .SETTLE_SAMPLES(12), .DEFAULT_SEL(3'd0)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int dec1_t [8] = '{40, 20, 10, 10, 5, 0, 0, 0};
    int dec2_t [8] = '{20, 20, 20, 10, 10, 0, 0, 0};

    function automatic bit ok(input int s);
        return s < 5;
    endfunction

    // model: host code pipeline, accepted code, clocks since flush start, strobes since flush end
    int h1, h2, h3, acc, since, strobes;
    int n_ack, n_err, n_clr, n_busy, n_valid, n_c1fl;
    bit fl, chg, s2;

    always @(negedge clock) begin
        if (!rst_n) begin
            h1 = 0; h2 = 0; h3 = 0; acc = 0; since = 0; strobes = 0;
        end
        fl  = since < 16;
        chg = ok(h2) && h2 != acc;
        s2  = bus.cic2_strobe;
        chk("dec1",        int'(bus.dec1),        dec1_t[acc]);
        chk("dec2",        int'(bus.dec2),        dec2_t[acc]);
        chk("cic_clr",     int'(bus.cic_clr),     int'(fl));
        chk("busy",        int'(bus.busy),        int'(strobes < 12));
        chk("cic1_strobe", int'(bus.cic1_strobe), int'(bus.in_strobe && !fl));
        chk("rate_ack",    int'(bus.rate_ack),    int'(!fl && strobes == 11 && s2 && !chg));
        chk("out_valid",   int'(bus.out_valid),   int'(!fl && strobes >= 12 && s2));
        chk("sel_err",     int'(bus.sel_err),     int'(!ok(h2) && h2 != h3));
        n_ack   += int'(bus.rate_ack);
        n_err   += int'(bus.sel_err);
        n_clr   += int'(bus.cic_clr);
        n_busy  += int'(bus.busy);
        n_valid += int'(bus.out_valid);
        n_c1fl  += int'(bus.cic1_strobe && bus.cic_clr);
        if (rst_n) begin
            if (chg) begin acc = h2; since = 0; strobes = 0; end
            else if (fl) since++;
            else if (s2 && strobes < 12) strobes++;
            h3 = h2; h2 = h1; h1 = int'(bus.rate_sel);
        end
    end

    bit rnd = 1'b1;

    task automatic step();
        @(posedge clock);
        #1;
        bus.in_strobe = 1'($urandom_range(0, 1));
        if (rnd) bus.cic2_strobe = ($urandom_range(0, 3) == 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clr_cnt();
        n_ack = 0; n_err = 0; n_clr = 0; n_busy = 0; n_valid = 0; n_c1fl = 0;
    endtask

    task automatic wait_settle(input string name);
        for (int i = 0; i < 200 && bus.cic_clr; i++) step();
        chk({name, " settle reached"}, int'(bus.cic_clr), 0);
    endtask

    task automatic wait_run(input string name);
        for (int i = 0; i < 2000 && bus.busy; i++) step();
        chk({name, " run reached"}, int'(bus.busy), 0);
    endtask

    initial begin
        bus.rate_sel = 3'd0; bus.in_strobe = 1'b0; bus.cic2_strobe = 1'b0;
        run(3);
        rst_n = 1'b1;
        clr_cnt();
        run(20);
        chk("t1 clr cycles", n_clr, 16);
        chk("t1 dec1", int'(bus.dec1), 40);
        chk("t1 dec2", int'(bus.dec2), 20);
        wait_run("t1");
        run(5);
        chk("t1 acks", n_ack, 1);

        clr_cnt();
        bus.rate_sel = 3'd3;
        run(3);
        chk("t2 dec1", int'(bus.dec1), 10);
        chk("t2 dec2", int'(bus.dec2), 10);
        wait_run("t2");
        run(3);
        chk("t2 clr cycles", n_clr, 16);
        chk("t2 strobe leak", n_c1fl, 0);
        chk("t2 acks", n_ack, 1);

        clr_cnt();
        bus.rate_sel = 3'd2;
        run(3);
        wait_settle("t3a");
        run(10);
        bus.rate_sel = 3'd4;
        run(3);
        wait_run("t3");
        run(3);
        chk("t3 acks", n_ack, 1);
        chk("t3 clr cycles", n_clr, 32);
        chk("t3 dec1", int'(bus.dec1), 5);
        chk("t3 dec2", int'(bus.dec2), 10);

        bus.rate_sel = 3'd1;
        run(3);
        wait_run("t4a");
        clr_cnt();
        bus.rate_sel = 3'd6;
        run(30);
        bus.rate_sel = 3'd1;
        run(5);
        chk("t4 sel_err pulses", n_err, 1);
        chk("t4 busy cycles", n_busy, 0);
        chk("t4 dec1", int'(bus.dec1), 20);
        chk("t4 dec2", int'(bus.dec2), 20);

        rnd = 1'b0; bus.cic2_strobe = 1'b0;
        bus.rate_sel = 3'd2;
        run(3);
        wait_settle("t5a");
        clr_cnt();
        repeat (11) begin
            bus.cic2_strobe = 1'b1; step();
            bus.cic2_strobe = 1'b0; step();
        end
        bus.rate_sel = 3'd3;
        step(); step();
        bus.cic2_strobe = 1'b1; step();
        bus.cic2_strobe = 1'b0;
        chk("t5 acks", n_ack, 0);
        chk("t5 valid", n_valid, 0);
        chk("t5 busy", int'(bus.busy), 1);
        chk("t5 clr", int'(bus.cic_clr), 1);
        rnd = 1'b1;
        wait_run("t5");
        run(3);
        chk("t5 final acks", n_ack, 1);
        chk("t5 dec1", int'(bus.dec1), 10);

        bus.rate_sel = 3'd4;
        run(3);
        wait_settle("t6a");
        run(5);
        rst_n = 1'b0;
        run(2);
        chk("t6 rst clr", int'(bus.cic_clr), 1);
        chk("t6 rst busy", int'(bus.busy), 1);
        chk("t6 rst dec1", int'(bus.dec1), 40);
        chk("t6 rst dec2", int'(bus.dec2), 20);
        rst_n = 1'b1;
        clr_cnt();
        run(3);
        wait_run("t6");
        run(3);
        chk("t6 clr cycles", n_clr, 19);
        chk("t6 acks", n_ack, 1);
        chk("t6 dec1", int'(bus.dec1), 5);

        repeat (40) begin
            bus.rate_sel = 3'($urandom_range(0, 7));
            run($urandom_range(2, 120));
        end
        run(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
